// File: rtl/fadd_operand_stage_pkg.sv
// Shared types and constants for the single-precision adder operand stage.
// Holds IEEE-754 field positions, operand classes and the FIFO entry layout.
package fadd_pkg;

  typedef enum logic [2:0] {
    ZERO   = 3'd0,
    DENORM = 3'd1,
    NORMAL = 3'd2,
    INF    = 3'd3,
    NAN    = 3'd4
  } fp_class_t;

  localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
  localparam logic [7:0]  FP_EXP_MAX = 8'hFF;

  localparam int SIGN_BIT = 31;
  localparam int EXP_HI   = 30;
  localparam int EXP_LO   = 23;
  localparam int MANT_HI  = 22;
  localparam int MANT_LO  = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        special;
    logic [31:0] special_val;
    fp_class_t   class_a;
    fp_class_t   class_b;
  } fadd_entry_t;

endpackage

// File: rtl/fadd_operand_stage_if.sv
// Operand-in / operand-out handshake bundle between producer, stage and adder.
// The stage takes the slave view; the environment driving it takes master.
interface fadd_operand_stage_if
  import fadd_pkg::*;
#(
  parameter int CNT_W = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_a;
  logic [31:0]      out_b;
  logic             out_special;
  logic [31:0]      out_special_val;
  fp_class_t        out_class_a;
  fp_class_t        out_class_b;
  logic [CNT_W-1:0] special_cnt;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_special, out_special_val,
           out_class_a, out_class_b, special_cnt
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_a, out_b, out_special, out_special_val,
           out_class_a, out_class_b, special_cnt
  );
endinterface

// File: rtl/fadd_operand_stage_classify.sv
// Combinational IEEE-754 single classifier; denormals come out flushed to
// a zero that keeps the operand's sign.
module fp_classify
  import fadd_pkg::*;
(
  input  logic [31:0] op_i,
  output fp_class_t   cls_o,
  output logic [31:0] flush_o
);
  logic [7:0]  exp_w;
  logic        mant_nz;

  assign exp_w   = op_i[EXP_HI:EXP_LO];
  assign mant_nz = |op_i[MANT_HI:MANT_LO];

  always_comb begin
    cls_o   = NORMAL;
    flush_o = op_i;
    if (exp_w == 8'h00) begin
      cls_o = mant_nz ? DENORM : ZERO;
      if (mant_nz) flush_o = {op_i[SIGN_BIT], 31'b0};
    end else if (exp_w == FP_EXP_MAX) begin
      cls_o = mant_nz ? NAN : INF;
    end
  end
endmodule

// File: rtl/fadd_operand_stage.sv
// Operand intake FIFO for the FP adder: classifies, flushes denormals and
// precomputes the override result for cases the adder datapath skips.
module fadd_operand_stage
  import fadd_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  fadd_operand_stage_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0] spc_q, spc_d;
  fadd_entry_t      mem_q [DEPTH];
  fadd_entry_t      new_e, head;
  logic             push, pop;

  fp_class_t   cls_a, cls_b;
  logic [31:0] fa, fb;

  fp_classify u_cls_a (.op_i(bus.in_a), .cls_o(cls_a), .flush_o(fa));
  fp_classify u_cls_b (.op_i(bus.in_b), .cls_o(cls_b), .flush_o(fb));

  // Rule evaluation runs on the flushed view: a denormal counts as zero.
  logic za, zb;
  assign za = (cls_a == ZERO) || (cls_a == DENORM);
  assign zb = (cls_b == ZERO) || (cls_b == DENORM);

  always_comb begin
    new_e             = '0;
    new_e.a           = fa;
    new_e.b           = fb;
    new_e.class_a     = cls_a;
    new_e.class_b     = cls_b;
    new_e.special     = 1'b1;
    if (cls_a == NAN || cls_b == NAN)
      new_e.special_val = FP_QNAN;
    else if (cls_a == INF && cls_b == INF)
      new_e.special_val = (fa[SIGN_BIT] != fb[SIGN_BIT]) ? FP_QNAN : fa;
    else if (cls_a == INF)
      new_e.special_val = fa;
    else if (cls_b == INF)
      new_e.special_val = fb;
    else if (za && zb)
      new_e.special_val = {fa[SIGN_BIT] & fb[SIGN_BIT], 31'b0};
    else if (za)
      new_e.special_val = fb;
    else if (zb)
      new_e.special_val = fa;
    else if (fa[30:0] == fb[30:0] && fa[SIGN_BIT] != fb[SIGN_BIT])
      new_e.special_val = 32'h0000_0000;
    else
      new_e.special     = 1'b0;
  end

  assign bus.in_ready  = (cnt_q < (PTR_W+1)'(DEPTH));
  assign bus.out_valid = (cnt_q != '0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    spc_d    = spc_q;
    if (push && new_e.special && spc_q != '1) spc_d = spc_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      spc_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      spc_q    <= spc_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever count is 0.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= new_e;
  end

  assign head                = bus.out_valid ? mem_q[rd_ptr_q] : '0;
  assign bus.out_a           = head.a;
  assign bus.out_b           = head.b;
  assign bus.out_special     = head.special;
  assign bus.out_special_val = head.special_val;
  assign bus.out_class_a     = head.class_a;
  assign bus.out_class_b     = head.class_b;
  assign bus.special_cnt     = spc_q;
endmodule

// File: tb/tb_fadd_operand_stage.sv
// Scoreboard bench for fadd_operand_stage: directed corner pairs, random
// traffic with random back-pressure, and an asynchronous reset mid-stream.
module tb_fadd_operand_stage;
  import fadd_pkg::*;

  localparam int DEPTH = 2;
  localparam int CNT_W = 3;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fadd_operand_stage_if #(.CNT_W(CNT_W)) bus ();

  fadd_operand_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct {
    logic [31:0] a, b, sv;
    logic        sp;
    fp_class_t   ca, cb;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_fail = 0;
  int   mdl_cnt = 0, exp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic fp_class_t kind(input logic [31:0] x);
    int e = int'(x[30:23]);
    int m = int'(x[22:0]);
    if (e == 0)   return (m == 0) ? ZERO : DENORM;
    if (e == 255) return (m == 0) ? INF : NAN;
    return NORMAL;
  endfunction

  // Reference written from the rule list: each operand reduced to a category
  // and a magnitude, then the first matching rule picks the result.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    bit   a_zero, b_zero;
    r.ca = kind(a);
    r.cb = kind(b);
    r.a  = (r.ca == DENORM) ? (a & 32'h8000_0000) : a;
    r.b  = (r.cb == DENORM) ? (b & 32'h8000_0000) : b;
    a_zero = (r.a[30:0] == 0);
    b_zero = (r.b[30:0] == 0);
    r.sp = 1'b1;
    r.sv = 32'h0;
    if (r.ca == NAN || r.cb == NAN)             r.sv = 32'h7FC0_0000;
    else if (r.ca == INF && r.cb == INF)        r.sv = (a[31] == b[31]) ? r.a : 32'h7FC0_0000;
    else if (r.ca == INF)                       r.sv = r.a;
    else if (r.cb == INF)                       r.sv = r.b;
    else if (a_zero && b_zero)                  r.sv = (a[31] && b[31]) ? 32'h8000_0000 : 32'h0;
    else if (a_zero)                            r.sv = r.b;
    else if (b_zero)                            r.sv = r.a;
    else if ((r.a ^ r.b) == 32'h8000_0000)      r.sv = 32'h0;
    else                                        r.sp = 1'b0;
    return r;
  endfunction

  // Monitor: compare the head whenever it is presented.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 32'd1, 32'd0);
      end else if (bus.out_ready) begin
        exp_t e;
        e = sb.pop_front();
        chk("out_a", bus.out_a, e.a);
        chk("out_b", bus.out_b, e.b);
        chk("out_special", 32'(bus.out_special), 32'(e.sp));
        chk("out_special_val", bus.out_special_val, e.sv);
        chk("out_class_a", 32'(bus.out_class_a), 32'(e.ca));
        chk("out_class_b", 32'(bus.out_class_b), 32'(e.cb));
      end else begin
        chk("stall_out_a", bus.out_a, sb[0].a);
        chk("stall_special_val", bus.out_special_val, sb[0].sv);
      end
    end
  end

  task automatic cyc(input logic v, input logic [31:0] a, input logic [31:0] b,
                     input logic ordy, output logic acc);
    logic popw;
    exp_t e;
    @(posedge clk); #1;
    bus.in_valid = v; bus.in_a = a; bus.in_b = b; bus.out_ready = ordy;
    @(negedge clk); #1;
    chk("in_ready", 32'(bus.in_ready), 32'(mdl_cnt < DEPTH));
    chk("out_valid", 32'(bus.out_valid), 32'(mdl_cnt > 0));
    chk("special_cnt", 32'(bus.special_cnt), 32'(exp_cnt));
    acc  = v && (mdl_cnt < DEPTH);
    popw = ordy && (mdl_cnt > 0);
    if (acc) begin
      e = model(a, b);
      sb.push_back(e);
      if (e.sp && exp_cnt < CMAX) exp_cnt++;
    end
    mdl_cnt = mdl_cnt + int'(acc) - int'(popw);
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic ordy);
    logic acc;
    int   n = 0;
    do begin
      cyc(1'b1, a, b, ordy, acc);
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 32'h0, 1'b1, acc);
  endtask

  function automatic logic [31:0] rand_op();
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 5))
      0: return r & 32'h8000_0000;
      1: return (r & 32'h807F_FFFF) | 32'h1;
      2: return (r & 32'h807F_FFFF) | 32'h7F80_0000;
      3: return r & 32'hFF80_0000 | 32'h7F80_0000;
      default: return (r[30:23] == 8'h00 || r[30:23] == 8'hFF) ? (r ^ 32'h4000_0000) : r;
    endcase
  endfunction

  initial begin
    logic acc;
    logic [31:0] a, b;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_a", bus.out_a, 32'h0);
    chk("rst_special_val", bus.out_special_val, 32'h0);
    chk("rst_class_a", 32'(bus.out_class_a), 32'(ZERO));
    chk("rst_special_cnt", 32'(bus.special_cnt), 32'd0);
    #10 rst_n = 1'b1;

    send(32'h3F80_0000, 32'h4000_0000, 1'b1);
    send(32'h7F80_0001, 32'h3F80_0000, 1'b1);
    send(32'h7F80_0000, 32'hFF80_0000, 1'b1);
    send(32'h0000_0001, 32'hC040_0000, 1'b1);
    send(32'h8000_0000, 32'h8000_0000, 1'b1);
    send(32'h4120_0000, 32'hC120_0000, 1'b1);
    send(32'hFF80_0000, 32'hFF80_0000, 1'b1);
    idle(3);

    // Back-pressure: third pair must bounce, then drain with overlap.
    cyc(1'b1, 32'h3F80_0000, 32'h3F80_0000, 1'b0, acc);
    cyc(1'b1, 32'h4040_0000, 32'hC040_0000, 1'b0, acc);
    cyc(1'b1, 32'h4080_0000, 32'h0000_0000, 1'b0, acc);
    chk("full_reject", 32'(acc), 32'd0);
    cyc(1'b1, 32'h4080_0000, 32'h0000_0000, 1'b1, acc);
    chk("full_pop_reject", 32'(acc), 32'd0);
    cyc(1'b1, 32'h4080_0000, 32'h0000_0000, 1'b1, acc);
    chk("overlap_accept", 32'(acc), 32'd1);
    cyc(1'b1, 32'h40A0_0000, 32'h40C0_0000, 1'b1, acc);
    idle(3);

    for (int i = 0; i < 1500; i++) begin
      a = rand_op();
      b = ($urandom_range(0, 7) == 0) ? (a ^ 32'h8000_0000) : rand_op();
      cyc(($urandom_range(0, 3) != 0), a, b, ($urandom_range(0, 3) != 0), acc);
    end
    idle(4);

    // Fill, then reset between edges.
    cyc(1'b1, 32'h3F80_0000, 32'h7F80_0000, 1'b0, acc);
    cyc(1'b1, 32'h7FC0_0000, 32'h3F80_0000, 1'b0, acc);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_special_cnt", 32'(bus.special_cnt), 32'd0);
    sb.delete();
    mdl_cnt = 0;
    exp_cnt = 0;
    @(posedge clk); #3 rst_n = 1'b1;
    send(32'h0000_0000, 32'h8000_0000, 1'b1);
    send(32'h3F80_0000, 32'h4000_0000, 1'b1);
    idle(4);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
